serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor computing a − b − bin one bit per clock, LSB first, with a single `full_subtractor` cell and a registered borrow. Sits between an operand producer and a result consumer, with a valid/ready handshake on each side. It trades WIDTH cycles of latency for one subtractor cell, for area-constrained datapaths.

---
 rtl/serial_sub_pkg.sv | 18 +
 rtl/full_subtractor.sv | 14 +
 rtl/serial_subtractor.sv | 100 ++++++++++
 tb/tb_serial_subtractor.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Holds the FSM state encoding and the bit-counter width derivation.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter only needs to reach WIDTH-1.
  function automatic int sub_cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: computes a - b - cin.
// Produces the difference bit and the borrow out of this bit position.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b ^ cin;
  assign borrow = (~a & b) | (~(a ^ b) & cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b - bin), LSB first, one bit per clock.
// Uses a single full_subtractor cell and a registered borrow between bit cycles.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CNT_W = sub_cnt_width(WIDTH);

  // Handshake: a transfer happens on any rising edge where valid && ready;
  // in_ready is high only in IDLE, out_valid only in DONE, both decoded from r_state.
  sub_state_t       r_state;
  sub_state_t       w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;
  logic             w_fs_diff;
  logic             w_fs_borrow;
  logic             w_last_bit;

  full_subtractor u_cell (
    .a      (r_a_sh[0]),
    .b      (r_b_sh[0]),
    .cin    (r_borrow),
    .diff   (w_fs_diff),
    .borrow (w_fs_borrow)
  );

  assign w_last_bit = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid) w_state_next = RUN;
      RUN:     if (w_last_bit) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_borrow <= bin;
            r_cnt    <= '0;
          end
        end
        RUN: begin
          // Result bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
          r_diff   <= {w_fs_diff, r_diff[WIDTH-1:1]};
          r_borrow <= w_fs_borrow;
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == DONE);
  assign diff       = r_diff;
  assign borrow_out = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor at WIDTH=8, plus an exhaustive
// WIDTH=4 sweep with random consumer stalls.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, bin8, bo8;
  logic [7:0] a8, b8, diff8;

  logic       in_valid4, in_ready4, out_valid4, out_ready4, bin4, bo4;
  logic [3:0] a4, b4, diff4;

  int tests_run;
  int tests_failed;

  logic [4:0] exp_q[$];

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .bin(bin8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .diff(diff8), .borrow_out(bo8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .bin(bin4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .diff(diff4), .borrow_out(bo4)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: issue one WIDTH=8 operation, return result and accept-to-valid latency.
  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                     output logic [7:0] od, output logic obo, output int lat);
    int n;
    n = 0;
    while (!in_ready8 && n < 30) begin tick(); n++; end
    a8 = ia; b8 = ib; bin8 = ibin; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 30) begin tick(); n++; end
    od = diff8; obo = bo8; lat = n;
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests_run++;
    if (in_ready8 !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got=%b exp=1", in_ready8); end
    tests_run++;
    if (out_valid8 !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", out_valid8); end
    tests_run++;
    if (diff8 !== 8'h00) begin tests_failed++; $display("FAIL reset_diff got=%h exp=00", diff8); end
    tests_run++;
    if (bo8 !== 1'b0) begin tests_failed++; $display("FAIL reset_borrow got=%b exp=0", bo8); end
    tests_run++;
    if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
      tests_failed++; $display("FAIL reset_w4 got ov=%b ir=%b exp ov=0 ir=1", out_valid4, in_ready4);
    end
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] d; logic bo; int lat;
    op8(8'h5A, 8'h3C, 1'b0, d, bo, lat);
    tests_run++;
    if (lat !== 8) begin tests_failed++; $display("FAIL basic_latency got=%0d exp=8", lat); end
    tests_run++;
    if (d !== 8'h1E) begin tests_failed++; $display("FAIL basic_diff got=%h exp=1e", d); end
    tests_run++;
    if (bo !== 1'b0) begin tests_failed++; $display("FAIL basic_borrow got=%b exp=0", bo); end
  endtask

  task automatic test_vectors();
    logic [7:0] va[3] = '{8'h00, 8'hFF, 8'h80};
    logic [7:0] vb[3] = '{8'h01, 8'hFF, 8'h7F};
    logic       vc[3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] vd[3] = '{8'hFF, 8'hFF, 8'h00};
    logic       ve[3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0] d; logic bo; int lat;
    for (int i = 0; i < 3; i++) begin
      op8(va[i], vb[i], vc[i], d, bo, lat);
      tests_run++;
      if (d !== vd[i] || bo !== ve[i]) begin
        tests_failed++;
        $display("FAIL vector%0d got diff=%h bo=%b exp diff=%h bo=%b", i, d, bo, vd[i], ve[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; in_valid8 = 1'b1;
    tick();
    a8 = 8'h07; b8 = 8'h02; bin8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 30) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || diff8 !== 8'h22 || bo8 !== 1'b0) begin
        tests_failed++;
        $display("FAIL backpressure_hold%0d got ov=%b ir=%b diff=%h bo=%b exp ov=1 ir=0 diff=22 bo=0",
                 i, out_valid8, in_ready8, diff8, bo8);
      end
      tick();
    end
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    tests_run++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      tests_failed++; $display("FAIL backpressure_release got ir=%b ov=%b exp ir=1 ov=0", in_ready8, out_valid8);
    end
    tick();
    in_valid8 = 1'b0;
    tests_run++;
    if (in_ready8 !== 1'b0) begin tests_failed++; $display("FAIL backpressure_accept got ir=%b exp=0", in_ready8); end
    n = 0;
    while (!out_valid8 && n < 30) begin tick(); n++; end
    tests_run++;
    if (n !== 8 || diff8 !== 8'h05 || bo8 !== 1'b0) begin
      tests_failed++; $display("FAIL backpressure_pending got lat=%0d diff=%h bo=%b exp lat=8 diff=05 bo=0", n, diff8, bo8);
    end
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] d; logic bo; int lat;
    a8 = 8'hF7; b8 = 8'h11; bin8 = 1'b0; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    tests_run++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || diff8 !== 8'h00) begin
      tests_failed++; $display("FAIL reset_mid_run got ov=%b ir=%b diff=%h exp ov=0 ir=1 diff=00", out_valid8, in_ready8, diff8);
    end
    tick();
    rst = 1'b0;
    tick();
    op8(8'h10, 8'h01, 1'b0, d, bo, lat);
    tests_run++;
    if (d !== 8'h0F || bo !== 1'b0 || lat !== 8) begin
      tests_failed++; $display("FAIL after_reset got diff=%h bo=%b lat=%0d exp diff=0f bo=0 lat=8", d, bo, lat);
    end
  endtask

  task automatic test_operand_change();
    int n;
    a8 = 8'hC3; b8 = 8'h42; bin8 = 1'b0; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    tick();
    a8 = 8'h00; b8 = 8'hFF; bin8 = 1'b1;
    n = 1;
    while (!out_valid8 && n < 30) begin tick(); n++; end
    tests_run++;
    if (diff8 !== 8'h81 || bo8 !== 1'b0) begin
      tests_failed++; $display("FAIL operand_change got diff=%h bo=%b exp diff=81 bo=0", diff8, bo8);
    end
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
  endtask

  // Scoreboard: expected {borrow, diff} pushed on accept, popped on result.
  task automatic test_exhaustive_w4();
    int n;
    logic [4:0] exp_v;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          n = 0;
          while (!in_ready4 && n < 20) begin tick(); n++; end
          a4 = ai[3:0]; b4 = bi[3:0]; bin4 = ci[0]; in_valid4 = 1'b1;
          tick();
          in_valid4 = 1'b0;
          exp_q.push_back({(ai < bi + ci) ? 1'b1 : 1'b0, 4'((ai - bi - ci) & 15)});
          n = 0;
          while (!out_valid4 && n < 20) begin tick(); n++; end
          repeat ($urandom_range(0, 2)) tick();
          exp_v = exp_q.pop_front();
          tests_run++;
          if (out_valid4 !== 1'b1 || {bo4, diff4} !== exp_v) begin
            tests_failed++;
            $display("FAIL w4 a=%h b=%h bin=%0d got ov=%b bo=%b diff=%h exp bo=%b diff=%h",
                     ai[3:0], bi[3:0], ci, out_valid4, bo4, diff4, exp_v[4], exp_v[3:0]);
          end
          out_ready4 = 1'b1;
          tick();
          out_ready4 = 1'b0;
        end
      end
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    rst = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_operand_change();
    test_exhaustive_w4();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
